// File: rtl/egress_mac.sv
// rtl/egress_mac.sv - 128-bit fabric words to 8-bit Ethernet byte stream with pad, FCS, IFG and tx stats
module egress_mac #(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_CYCLES  = 12,
    parameter int CNT_W       = 32
) (
    input  logic             lcl_clk,
    input  logic             reset,
    input  logic             sof_in,
    input  logic             eof_in,
    input  logic             valid_in,
    input  logic [3:0]       bytes_in,
    input  logic [127:0]     data_in,
    output logic             ready_out,
    output logic             sof_out,
    output logic             eof_out,
    output logic             valid_out,
    output logic [7:0]       data_out,
    output logic [CNT_W-1:0] tx_frames,
    output logic [CNT_W-1:0] tx_octets,
    output logic [CNT_W-1:0] tx_drops
);
    typedef enum logic [2:0] {S_IDLE, S_SOF, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

    localparam logic [10:0] L_MIN = 11'(MIN_PAYLOAD);
    localparam logic [15:0] L_IFG = 16'(IFG_CYCLES > 0 ? IFG_CYCLES - 1 : 0);

    state_t         r_state;
    logic [127:0]   r_sh_data, r_hd_data;
    logic [4:0]     r_sh_left, r_hd_left;
    logic           r_sh_eof, r_hd_eof, r_hd_valid;
    logic           r_in_frame;
    logic [31:0]    r_crc;
    logic [10:0]    r_cnt;
    logic [1:0]     r_fcs_idx;
    logic [15:0]    r_ifg;

    logic           w_xfer, w_drop, w_accept, w_use_sh, w_have, w_cur_eof;
    logic [4:0]     w_in_left, w_cur_left;
    logic [127:0]   w_cur_data;
    logic [7:0]     w_byte, w_fcs_byte;
    logic [10:0]    w_cnt_inc;
    logic [31:0]    w_fcs;

    function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] v;
        v = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        return v;
    endfunction

    // A sof word is only legal outside a frame; a continuation word only inside one.
    assign ready_out  = ~r_hd_valid;
    assign w_xfer     = valid_in & ready_out;
    assign w_drop     = w_xfer & (r_in_frame ? sof_in : ~sof_in);
    assign w_accept   = w_xfer & ~w_drop;
    assign w_in_left  = eof_in ? ((bytes_in == 4'd0) ? 5'd16 : {1'b0, bytes_in}) : 5'd16;

    // Bytes come from the shift register, or straight from holding once it runs dry.
    assign w_use_sh   = (r_sh_left != 5'd0);
    assign w_have     = w_use_sh | r_hd_valid;
    assign w_cur_data = w_use_sh ? r_sh_data : r_hd_data;
    assign w_cur_left = w_use_sh ? r_sh_left : r_hd_left;
    assign w_cur_eof  = w_use_sh ? r_sh_eof  : r_hd_eof;
    assign w_byte     = w_cur_data[127:120];
    assign w_cnt_inc  = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
    assign w_fcs      = ~r_crc;
    assign w_fcs_byte = w_fcs[{r_fcs_idx, 3'b000} +: 8];

    always_ff @(posedge lcl_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sh_data  <= '0;
            r_sh_left  <= '0;
            r_sh_eof   <= 1'b0;
            r_hd_data  <= '0;
            r_hd_left  <= '0;
            r_hd_eof   <= 1'b0;
            r_hd_valid <= 1'b0;
            r_in_frame <= 1'b0;
            r_crc      <= 32'hFFFFFFFF;
            r_cnt      <= '0;
            r_fcs_idx  <= '0;
            r_ifg      <= '0;
            sof_out    <= 1'b0;
            eof_out    <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            tx_frames  <= '0;
            tx_octets  <= '0;
            tx_drops   <= '0;
        end else begin
            sof_out   <= 1'b0;
            eof_out   <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            if (w_drop)
                tx_drops <= tx_drops + CNT_W'(1);
            if (w_accept)
                r_in_frame <= ~eof_in;
            if (w_accept && r_state != S_IDLE) begin
                r_hd_data  <= data_in;
                r_hd_left  <= w_in_left;
                r_hd_eof   <= eof_in;
                r_hd_valid <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_hd_valid || w_accept) begin
                        r_sh_data  <= r_hd_valid ? r_hd_data : data_in;
                        r_sh_left  <= r_hd_valid ? r_hd_left : w_in_left;
                        r_sh_eof   <= r_hd_valid ? r_hd_eof  : eof_in;
                        r_hd_valid <= 1'b0;
                        r_crc      <= 32'hFFFFFFFF;
                        r_cnt      <= '0;
                        sof_out    <= 1'b1;
                        r_state    <= S_SOF;
                    end
                end
                S_SOF, S_DATA: begin
                    r_state <= S_DATA;
                    if (w_have) begin
                        valid_out <= 1'b1;
                        data_out  <= w_byte;
                        r_crc     <= f_crc8(r_crc, w_byte);
                        r_cnt     <= w_cnt_inc;
                        tx_octets <= tx_octets + CNT_W'(1);
                        if (!w_use_sh)
                            r_hd_valid <= 1'b0;
                        if (w_cur_left == 5'd1) begin
                            if (w_cur_eof) begin
                                r_sh_left <= '0;
                                r_fcs_idx <= '0;
                                r_state   <= (w_cnt_inc < L_MIN) ? S_PAD : S_FCS;
                            end else if (w_use_sh && r_hd_valid) begin
                                r_sh_data  <= r_hd_data;
                                r_sh_left  <= r_hd_left;
                                r_sh_eof   <= r_hd_eof;
                                r_hd_valid <= 1'b0;
                            end else begin
                                r_sh_left <= '0;
                            end
                        end else begin
                            r_sh_data <= w_cur_data << 8;
                            r_sh_left <= w_cur_left - 5'd1;
                            r_sh_eof  <= w_cur_eof;
                        end
                    end
                end
                S_PAD: begin
                    valid_out <= 1'b1;
                    r_crc     <= f_crc8(r_crc, 8'h00);
                    r_cnt     <= w_cnt_inc;
                    tx_octets <= tx_octets + CNT_W'(1);
                    if (w_cnt_inc >= L_MIN)
                        r_state <= S_FCS;
                end
                S_FCS: begin
                    valid_out <= 1'b1;
                    data_out  <= w_fcs_byte;
                    tx_octets <= tx_octets + CNT_W'(1);
                    r_fcs_idx <= r_fcs_idx + 2'd1;
                    if (r_fcs_idx == 2'd3) begin
                        eof_out   <= 1'b1;
                        tx_frames <= tx_frames + CNT_W'(1);
                        r_ifg     <= L_IFG;
                        r_state   <= (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
                    end
                end
                S_IFG: begin
                    if (r_ifg == 16'd0)
                        r_state <= S_IDLE;
                    else
                        r_ifg <= r_ifg - 16'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_egress_mac.sv
// tb/tb_egress_mac.sv - directed self-checking bench for egress_mac
module tb_egress_mac;
    localparam int MINP = 60;
    localparam int IFG  = 12;

    logic         lcl_clk = 1'b0;
    logic         reset = 1'b1;
    logic         sof_in = 1'b0, eof_in = 1'b0, valid_in = 1'b0;
    logic [3:0]   bytes_in = '0;
    logic [127:0] data_in = '0;
    logic         ready_out, sof_out, eof_out, valid_out;
    logic [7:0]   data_out;
    logic [31:0]  tx_frames, tx_octets, tx_drops;
    logic         ready_out_0, sof_out_0, eof_out_0, valid_out_0;
    logic [7:0]   data_out_0;
    logic [31:0]  tx_frames_0, tx_octets_0, tx_drops_0;

    always #4 lcl_clk = ~lcl_clk;

    egress_mac #(.MIN_PAYLOAD(MINP), .IFG_CYCLES(IFG), .CNT_W(32)) u_dut (
        .lcl_clk(lcl_clk), .reset(reset), .sof_in(sof_in), .eof_in(eof_in),
        .valid_in(valid_in), .bytes_in(bytes_in), .data_in(data_in),
        .ready_out(ready_out), .sof_out(sof_out), .eof_out(eof_out),
        .valid_out(valid_out), .data_out(data_out), .tx_frames(tx_frames),
        .tx_octets(tx_octets), .tx_drops(tx_drops)
    );

    egress_mac #(.MIN_PAYLOAD(0), .IFG_CYCLES(IFG), .CNT_W(32)) u_dut0 (
        .lcl_clk(lcl_clk), .reset(reset), .sof_in(sof_in), .eof_in(eof_in),
        .valid_in(valid_in), .bytes_in(bytes_in), .data_in(data_in),
        .ready_out(ready_out_0), .sof_out(sof_out_0), .eof_out(eof_out_0),
        .valid_out(valid_out_0), .data_out(data_out_0), .tx_frames(tx_frames_0),
        .tx_octets(tx_octets_0), .tx_drops(tx_drops_0)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         cyc = 0;
    logic [7:0] rx_q[$];
    int         sof_c[$];
    int         eof_c[$];
    int         gap_n = 0;
    logic       in_f = 1'b0;
    logic [7:0] rx0_q[$];
    int         sof0_n = 0, eof0_n = 0;
    logic [7:0] eof0_byte = '0;

    always @(negedge lcl_clk) begin
        cyc++;
        if (reset) begin
            in_f = 1'b0;
        end else begin
            if (sof_out) begin
                sof_c.push_back(cyc);
                in_f = 1'b1;
            end else if (in_f && !valid_out) begin
                gap_n++;
            end
            if (valid_out) rx_q.push_back(data_out);
            if (eof_out) begin
                eof_c.push_back(cyc);
                in_f = 1'b0;
            end
            if (sof_out_0) sof0_n++;
            if (valid_out_0) rx0_q.push_back(data_out_0);
            if (eof_out_0) begin
                eof0_n++;
                eof0_byte = data_out_0;
            end
        end
    end

    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    int exp_frames = 0, exp_octets = 0, exp_drops = 0;
    int last_xfer = 0;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] v;
        v = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        return v;
    endfunction

    // Appends one expected wire frame (payload, zero pad, FCS low byte first).
    task automatic build_exp(input int minp);
        logic [7:0]  f[$];
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        f = pay_q;
        while (f.size() < minp) f.push_back(8'h00);
        foreach (f[i]) c = crc_byte(c, f[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
        foreach (f[i]) exp_q.push_back(f[i]);
        exp_octets += f.size();
        exp_frames++;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        sof_c.delete();
        eof_c.delete();
        exp_q.delete();
        gap_n = 0;
    endtask

    task automatic send_word(input logic s, input logic e, input logic [3:0] b, input logic [127:0] d);
        int budget;
        budget = 400;
        sof_in = s; eof_in = e; bytes_in = b; data_in = d; valid_in = 1'b1;
        while (!ready_out && budget > 0) begin
            @(posedge lcl_clk); #1;
            budget--;
        end
        if (budget == 0) check("ready_wait", 64'(ready_out), 64'd1);
        @(posedge lcl_clk); #1;
        last_xfer = cyc;
        valid_in = 1'b0; sof_in = 1'b0; eof_in = 1'b0;
    endtask

    task automatic send_frame(input int stall_after, input int stall_cyc, input logic junk);
        int n, nw, nb;
        logic [127:0] d;
        n  = pay_q.size();
        nw = (n + 15) / 16;
        for (int w = 0; w < nw; w++) begin
            d  = '0;
            nb = (n - 16*w > 16) ? 16 : n - 16*w;
            for (int i = 0; i < nb; i++) d[127-8*i -: 8] = pay_q[16*w+i];
            send_word(w == 0, w == nw - 1, 4'(nb), d);
            if (junk && w == 0) begin
                send_word(1'b1, 1'b0, 4'd0, {16{8'hEE}});
                exp_drops++;
            end
            if (w == stall_after) begin
                repeat (stall_cyc) @(posedge lcl_clk);
                #1;
            end
        end
    endtask

    task automatic wait_done(input int n_eof);
        int budget;
        budget = 3000;
        while (eof_c.size() < n_eof && budget > 0) begin
            @(posedge lcl_clk);
            budget--;
        end
        check("eof_wait", 64'(eof_c.size()), 64'(n_eof));
        repeat (IFG + 4) @(posedge lcl_clk);
        #1;
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_frames"}, 64'(tx_frames), 64'(exp_frames));
        check({tag, "_octets"}, 64'(tx_octets), 64'(exp_octets));
        check({tag, "_drops"},  64'(tx_drops),  64'(exp_drops));
    endtask

    initial begin
        logic [7:0] t1_q[$];
        int budget;
        t1_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};

        repeat (3) @(posedge lcl_clk);
        #1;
        check("rst_ready", 64'(ready_out), 64'd1);
        check("rst_sof",   64'(sof_out),   64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_eof",   64'(eof_out),   64'd0);
        check_stats("rst");
        reset = 1'b0;
        repeat (2) @(posedge lcl_clk);
        #1;

        // 1: check string, no padding on u_dut0; padded copy on u_dut
        clear_rx();
        pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        build_exp(MINP);
        send_frame(-1, 0, 1'b0);
        wait_done(1);
        check("t1_sof_lat", 64'(sof_c.size() > 0 ? sof_c[0] - last_xfer : -1), 64'd1);
        check("t1_gap", 64'(gap_n), 64'd0);
        check("t1_len0", 64'(rx0_q.size()), 64'(t1_q.size()));
        for (int i = 0; i < t1_q.size() && i < rx0_q.size(); i++)
            check($sformatf("t1_b0_%0d", i), 64'(rx0_q[i]), 64'(t1_q[i]));
        check("t1_sof0", 64'(sof0_n), 64'd1);
        check("t1_eof0", 64'(eof0_n), 64'd1);
        check("t1_eofbyte0", 64'(eof0_byte), 64'hCB);
        check("t1_octets0", 64'(tx_octets_0), 64'd13);
        check("t1_frames0", 64'(tx_frames_0), 64'd1);
        compare_rx("t1pad");
        check_stats("t1");

        // 2: 14-byte frame padded to 60 plus FCS
        clear_rx();
        pay_q.delete();
        for (int i = 0; i < 14; i++) pay_q.push_back(8'(i * 7 + 3));
        build_exp(MINP);
        send_frame(-1, 0, 1'b0);
        wait_done(1);
        check("t2_total", 64'(rx_q.size()), 64'd64);
        compare_rx("t2");
        check("t2_gap", 64'(gap_n), 64'd0);
        check_stats("t2");

        // 3: two 80-byte frames back to back, exact inter-frame gap
        clear_rx();
        pay_q.delete();
        for (int i = 0; i < 80; i++) pay_q.push_back(8'(i + 8'h40));
        build_exp(MINP);
        send_frame(-1, 0, 1'b0);
        pay_q.delete();
        for (int i = 0; i < 80; i++) pay_q.push_back(8'(255 - i));
        build_exp(MINP);
        send_frame(-1, 0, 1'b0);
        wait_done(2);
        compare_rx("t3");
        check("t3_gap", 64'(gap_n), 64'd0);
        check("t3_sofs", 64'(sof_c.size()), 64'd2);
        if (sof_c.size() == 2 && eof_c.size() == 2)
            check("t3_ifg", 64'(sof_c[1] - eof_c[0]), 64'(IFG + 1));
        check_stats("t3");

        // 4: fabric underrun; buffers absorb 30 cycles, the rest shows on the wire
        clear_rx();
        pay_q.delete();
        for (int i = 0; i < 48; i++) pay_q.push_back(8'(i * 13 + 1));
        build_exp(MINP);
        send_frame(1, 35, 1'b0);
        wait_done(1);
        compare_rx("t4");
        check("t4_gap", 64'(gap_n), 64'd5);
        check_stats("t4");

        // 5: non-sof word in IDLE and sof word mid-frame are both dropped
        clear_rx();
        send_word(1'b0, 1'b1, 4'd5, {16{8'hA5}});
        exp_drops++;
        repeat (4) @(posedge lcl_clk);
        #1;
        check("t5_idle_drop", 64'(tx_drops), 64'(exp_drops));
        check("t5_no_sof", 64'(sof_c.size()), 64'd0);
        pay_q.delete();
        for (int i = 0; i < 32; i++) pay_q.push_back(8'(i ^ 8'h5A));
        build_exp(MINP);
        send_frame(-1, 0, 1'b1);
        wait_done(1);
        compare_rx("t5");
        check("t5_drops", 64'(tx_drops), 64'd2);
        check_stats("t5");

        // 6: asynchronous reset during the second FCS byte
        clear_rx();
        pay_q.delete();
        for (int i = 0; i < 20; i++) pay_q.push_back(8'(i + 1));
        send_frame(-1, 0, 1'b0);
        budget = 500;
        while (rx_q.size() < 61 && budget > 0) begin
            @(posedge lcl_clk); #1;
            budget--;
        end
        check("t6_reach_fcs", 64'(rx_q.size()), 64'd61);
        check("t6_fcs2_valid", 64'(valid_out), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_async_valid", 64'(valid_out), 64'd0);
        check("t6_async_data",  64'(data_out),  64'd0);
        check("t6_async_frames", 64'(tx_frames), 64'd0);
        check("t6_async_octets", 64'(tx_octets), 64'd0);
        check("t6_async_ready", 64'(ready_out), 64'd1);
        repeat (3) @(posedge lcl_clk);
        #1;
        check("t6_no_eof", 64'(eof_c.size()), 64'd0);
        check("t6_eof_low", 64'(eof_out), 64'd0);
        reset = 1'b0;
        exp_frames = 0; exp_octets = 0; exp_drops = 0;
        repeat (2) @(posedge lcl_clk);
        #1;
        clear_rx();
        pay_q.delete();
        for (int i = 0; i < 20; i++) pay_q.push_back(8'(8'hC0 + i));
        build_exp(MINP);
        send_frame(-1, 0, 1'b0);
        wait_done(1);
        compare_rx("t6");
        check_stats("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
